// File: rtl/hs_sink_checker.sv
// hs_sink_checker: ready/valid sink that accepts a fixed number of beats, applies
// optional LFSR-driven backpressure and checks that the data forms an
// incrementing sequence (mod 2^DATA_W).
module hs_sink_checker #(
  parameter int unsigned DATA_W    = 3,
  parameter int unsigned NUM_BEATS = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              stall_en,
  input  logic              valid_down,
  input  logic [DATA_W-1:0] data_down,
  output logic              ready_down,
  output logic [DATA_W-1:0] result,
  output logic [15:0]       beat_cnt,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              done
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ERR_W  = 8;
  localparam int unsigned LFSR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   lfsr_next;
  logic [DATA_W-1:0]   expected;
  logic                ready_next;
  logic                xfer_c;
  logic                start_c;
  logic                last_beat_c;

  // ready_down is registered, so a transfer is only possible while in RUN
  assign xfer_c      = valid_down & ready_down;
  assign last_beat_c = (beat_cnt == CNT_W'(NUM_BEATS - 1));
  assign start_c     = (state == IDLE) & (state_next == RUN);

  // Next-state, LFSR step and next ready value
  always_comb begin
    state_next = state;
    lfsr_next  = lfsr;
    ready_next = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
      end
      RUN: begin
        // Dropping enable wins over a same-cycle final transfer
        if (!enable)                     state_next = IDLE;
        else if (xfer_c && last_beat_c)  state_next = DONE;
      end
      DONE: begin
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, advances only while running
    if (state == RUN) begin
      lfsr_next = {lfsr[LFSR_W-2:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    ready_next = (state_next == RUN) & ~(stall_en & lfsr_next[0]);
  end

  // State, LFSR and handshake/status registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      ready_down <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      lfsr       <= lfsr_next;
      ready_down <= ready_next;
      done       <= (state_next == DONE);
    end
  end

  // Datapath: capture accepted beats and track sequence errors
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
      expected <= '0;
    end else if (start_c) begin
      beat_cnt <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
      expected <= '0;
    end else if (xfer_c) begin
      result   <= data_down;
      beat_cnt <= beat_cnt + CNT_W'(1);
      // Resync to the received value so one bad beat counts once
      expected <= data_down + DATA_W'(1);
      if (data_down != expected) begin
        err <= 1'b1;
        if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: doc/hs_sink_checker.md
HS_SINK_CHECKER -- requirements
Module: hs_sink_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 3, meaning width of data_down and result.
REQ-002 SHALL have parameter NUM_BEATS, default 16, meaning accepted beats per run before DONE.
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, meaning stall-pattern LFSR reset value; nonzero.
REQ-004 SHALL have port sys_clk  input  1  sole clock; all flops rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  starts or holds a run; low returns the block to IDLE.
REQ-007 SHALL have port stall_en  input  1  enables pseudo-random backpressure.
REQ-008 SHALL have port valid_down  input  1  upstream data valid.
REQ-009 SHALL have port data_down  input  DATA_W  upstream data.
REQ-010 SHALL have port ready_down  output  1  sink ready; registered.
REQ-011 SHALL have port result  output  DATA_W  last accepted data.
REQ-012 SHALL have port beat_cnt  output  16  accepted beats in current run.
REQ-013 SHALL have port err  output  1  sticky sequence-mismatch flag.
REQ-014 SHALL have port err_cnt  output  8  mismatch count; saturates at 255.
REQ-015 SHALL have port done  output  1  high while in DONE.

Function
REQ-016 SHALL define transfer as valid_down=1 and ready_down=1 at a rising sys_clk edge; no other condition accepts data.
REQ-017 SHALL drive ready_down from a flop only; no combinational path from valid_down or data_down to ready_down.
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 SHALL go IDLE->RUN when enable=1; on this transition clear beat_cnt, err, err_cnt, expected value (to 0).
REQ-020 SHALL go RUN->DONE on the transfer that makes beat_cnt equal NUM_BEATS.
REQ-021 SHALL go RUN->IDLE or DONE->IDLE when enable=0; enable=0 takes priority over a same-cycle final transfer (that transfer still counts).
REQ-022 SHALL register ready_down_next = (state_next==RUN) & ~(stall_en & lfsr_next[0]); ready_down is 0 the cycle after the final beat and in IDLE/DONE.
REQ-023 SHALL implement 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advancing one step per cycle only in RUN.
REQ-024 SHALL on each transfer: result<=data_down; beat_cnt<=beat_cnt+1; expected<=data_down+1 mod 2^DATA_W.
REQ-025 SHALL flag mismatch when transfer data_down != expected: set err (sticky until next IDLE->RUN), err_cnt+1 saturating at 255; resync per REQ-024.
REQ-026 SHALL hold result, beat_cnt, err, err_cnt in IDLE and DONE; values visible until next run starts.
REQ-027 SHALL ignore valid_down and data_down when ready_down=0; upstream holding data across stalls is not checked.
REQ-028 SHALL wrap expected value 2^DATA_W-1 -> 0 without error (7->0 for DATA_W=3).
REQ-029 SHALL drive done=1 exactly while state==DONE.

Reset
REQ-030 SHALL on rst=1 immediately set state=IDLE, ready_down=0, result=0, beat_cnt=0, err=0, err_cnt=0, done=0, expected=0, lfsr=LFSR_SEED.
REQ-031 SHALL after rst deasserts with enable=1 enter RUN on the first edge and assert ready_down on that edge (subject to stall).
REQ-032 SHALL on rst mid-run discard the run; no partial beat counted.

Verification
REQ-033 SHALL cover: enable=1, stall_en=0, valid_down=1 always, data 0,1,...,7,0,...,7 -> ready_down high 16 cycles, beat_cnt=16, done=1, err=0, result=7, ready_down=0.
REQ-034 SHALL cover: same with stall_en=1 -> ready_down follows LFSR from seed 8'hA5, 16 transfers only on ready&valid, err=0.
REQ-035 SHALL cover: sequence 0,1,2,5,6 -> err=1 at beat 4, err_cnt=1, no further error on 6, result=6.
REQ-036 SHALL cover: enable dropped at beat_cnt=5 -> IDLE, ready_down=0 next cycle, beat_cnt=5 held; re-enable clears to 0.
REQ-037 SHALL cover: rst pulsed during RUN at beat_cnt=9 -> all outputs 0 asynchronously, RUN re-entered after release.
REQ-038 SHALL cover: valid_down toggling randomly with stall_en=1 -> transfer count equals beat_cnt; no acceptance while ready_down=0.
